// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bit-serial W-bit adder sequencer: one full-adder cell built from two half adders,
// fed LSB-first from operand shift registers, with a start/done handshake.

module serial_adder_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int W  = 8,
    localparam int CW = $clog2(W)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] a_in_i,
    input  logic [W-1:0] b_in_i,
    input  logic         cin_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         ovf_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic ha0_s, ha0_c, s_bit, ha1_c, carry_nxt;

    serial_adder_ha u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(ha0_s), .c_o(ha0_c));
    serial_adder_ha u_ha1 (.a_i(ha0_s),  .b_i(carry_q), .s_o(s_bit), .c_o(ha1_c));
    assign carry_nxt = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = a_in_i;
                    b_d     = b_in_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = carry_nxt;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {s_bit, sum_q[W-1:1]};
                if (cnt_q == LAST) begin
                    // carry_q here is the carry into the MSB; overflow when it differs from cout
                    cout_d  = carry_nxt;
                    ovf_d   = carry_q ^ carry_nxt;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
    assign done_o  = (state_q == S_DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench: expected {ovf,cout,sum} queued at each accepted start,
// popped and compared whenever a done pulse is seen.

module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, ready8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, ready4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int n_vec = 0;
    int n_err = 0;
    int n_done8 = 0;
    int n_done4 = 0;
    logic [9:0] q8[$];
    logic [5:0] q4[$];

    serial_adder_ctrl #(.W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_in_i(a8), .b_in_i(b8),
        .cin_i(cin8), .ready_o(ready8), .busy_o(busy8), .done_o(done8),
        .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8)
    );

    serial_adder_ctrl #(.W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_in_i(a4), .b_in_i(b4),
        .cin_i(cin4), .ready_o(ready4), .busy_o(busy4), .done_o(done4),
        .sum_o(sum4), .cout_o(cout4), .ovf_o(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {8'd0, c};
        ovf  = (a[7] == b[7]) && (full[7] != a[7]);
        return {ovf, full[8], full[7:0]};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {4'd0, c};
        ovf  = (a[3] == b[3]) && (full[3] != a[3]);
        return {ovf, full[4], full[3:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && done8) begin
            n_done8++;
            if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
            else                chk("res8", {22'd0, ovf8, cout8, sum8}, {22'd0, q8.pop_front()});
        end
        if (!rst && done4) begin
            n_done4++;
            if (q4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
            else                chk("res4", {26'd0, ovf4, cout4, sum4}, {26'd0, q4.pop_front()});
        end
    end

    // Entered and left just after a rising edge; checks the exact W+2 cycle timeline.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [9:0] e;
        e = model8(a, b, c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        chk("ready_pre", {31'd0, ready8}, 32'd1);
        @(posedge clk);
        q8.push_back(e);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("run_flags", {29'd0, busy8, done8, ready8}, 32'b100);
            @(posedge clk);
        end
        @(negedge clk);
        chk("done_flags", {29'd0, busy8, done8, ready8}, 32'b110);
        @(posedge clk);
        @(negedge clk);
        chk("idle_flags", {29'd0, busy8, done8, ready8}, 32'b001);
        chk("held_result", {22'd0, ovf8, cout8, sum8}, {22'd0, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d0;
        logic ok;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flags8", {29'd0, ready8, busy8, done8}, 32'b100);
        chk("rst_res8", {22'd0, ovf8, cout8, sum8}, 32'd0);
        chk("rst_flags4", {29'd0, ready4, busy4, done4}, 32'b100);
        @(posedge clk);
        #1;

        // directed adds
        add8(8'h0F, 8'h01, 1'b0);
        add8(8'hFF, 8'h01, 1'b0);
        add8(8'h7F, 8'h01, 1'b0);
        add8(8'h80, 8'h80, 1'b1);
        add8(8'hA5, 8'h5A, 1'b1);

        // start pulses during RUN and DONE must be ignored
        d0 = n_done8;
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        q8.push_back(model8(8'h03, 8'h04, 1'b0));
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 start8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
        @(posedge clk);
        #1 start8 = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done8) begin ok = 1'b1; break; end
        end
        chk("ign_done_seen", {31'd0, ok}, 32'd1);
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        chk("ign_idle", {29'd0, busy8, done8, ready8}, 32'b001);
        chk("ign_sum", {24'd0, sum8}, 32'h07);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            chk("ign_no_second", {31'd0, busy8}, 32'd0);
        end
        chk("ign_one_done", n_done8 - d0, 32'd1);
        @(posedge clk);
        #1;

        // reset mid-RUN aborts without a done pulse
        d0 = n_done8;
        a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_flags", {29'd0, busy8, done8, ready8}, 32'b001);
        chk("abort_res", {22'd0, ovf8, cout8, sum8}, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", n_done8 - d0, 32'd0);
        @(posedge clk);
        #1;
        add8(8'h01, 8'h01, 1'b1);

        // W=4 exhaustive, back-to-back with start held high
        start4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a4 = i[8:5]; b4 = i[4:1]; cin4 = i[0];
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (ready4) begin ok = 1'b1; break; end
            end
            if (!ok) chk("ready4_timeout", 32'd0, 32'd1);
            @(posedge clk);
            q4.push_back(model4(a4, b4, cin4));
            #1;
        end
        start4 = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (q4.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain4", q4.size(), 32'd0);
        chk("n_done4", n_done4, 32'd512);
        chk("n_done8", n_done8, 32'd7);
        chk("drain8", q8.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
